// File: rtl/wrapper_req_sched.sv
// Round-robin scheduler that shares one password-encryption wrapper among
// NUM_REQ clients, owns the master key register and gates traffic on wrapper boot.
module wrapper_req_sched #(
   parameter int NUM_REQ = 4,
   parameter int DATA_W  = 128,
   parameter int TIMEOUT = 1024
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [NUM_REQ-1:0]          req_valid,
   output logic [NUM_REQ-1:0]          req_ready,
   input  logic [NUM_REQ*DATA_W-1:0]   req_account,
   input  logic [NUM_REQ*DATA_W-1:0]   req_password,
   input  logic                        mk_load,
   input  logic [DATA_W-1:0]           master_key_in,
   output logic [NUM_REQ-1:0]          resp_valid,
   output logic [DATA_W-1:0]           resp_data,
   output logic                        resp_err,
   output logic                        busy,
   output logic [DATA_W-1:0]           account,
   output logic [DATA_W-1:0]           password,
   output logic [DATA_W-1:0]           master_key,
   output logic                        go,
   input  logic [DATA_W-1:0]           password_enc,
   input  logic                        boot_done_signal,
   input  logic                        done
);

   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int CNT_W = $clog2(TIMEOUT);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_REQ - 1);

   typedef enum logic [2:0] {
      S_BOOT,
      S_IDLE,
      S_ISSUE,
      S_WAIT,
      S_RESP
   } state_t;

   state_t             state;
   state_t             state_nxt;
   logic [IDX_W-1:0]   rr_ptr;
   logic [IDX_W-1:0]   grant;
   logic [IDX_W-1:0]   winner;
   logic               found;
   logic               handshake;
   logic [CNT_W-1:0]   cnt;
   logic [DATA_W-1:0]  key_reg;
   logic [DATA_W-1:0]  acct_slice [NUM_REQ];
   logic [DATA_W-1:0]  pass_slice [NUM_REQ];

   // Unpack the flat client buses so the winner can pick its slice by index.
   always_comb begin
      for (int i = 0; i < NUM_REQ; i++) begin
         acct_slice[i] = req_account[i*DATA_W +: DATA_W];
         pass_slice[i] = req_password[i*DATA_W +: DATA_W];
      end
   end

   // Round-robin search starting at rr_ptr; the first valid client wins.
   always_comb begin
      int idx;
      found  = 1'b0;
      winner = '0;
      idx    = 0;
      for (int k = 0; k < NUM_REQ; k++) begin
         idx = (int'(rr_ptr) + k) % NUM_REQ;
         if (!found && req_valid[IDX_W'(idx)]) begin
            found  = 1'b1;
            winner = IDX_W'(idx);
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= S_BOOT;
      end else begin
         state <= state_nxt;
      end
   end

   // Next state plus the combinational grant; a dropped boot_done in IDLE
   // blocks the grant in the same cycle it is seen.
   always_comb begin
      state_nxt = state;
      req_ready = '0;
      handshake = 1'b0;
      unique case (state)
         S_BOOT: begin
            if (boot_done_signal) begin
               state_nxt = S_IDLE;
            end
         end
         S_IDLE: begin
            if (!boot_done_signal) begin
               state_nxt = S_BOOT;
            end else if (found) begin
               req_ready[winner] = 1'b1;
               handshake         = 1'b1;
               state_nxt         = S_ISSUE;
            end
         end
         S_ISSUE: begin
            state_nxt = S_WAIT;
         end
         S_WAIT: begin
            if (done || (cnt == CNT_LAST)) begin
               state_nxt = S_RESP;
            end
         end
         S_RESP: begin
            state_nxt = S_IDLE;
         end
         default: begin
            state_nxt = S_BOOT;
         end
      endcase
   end

   always_comb begin
      resp_valid = '0;
      if (state == S_RESP) begin
         resp_valid[grant] = 1'b1;
      end
   end

   assign go         = (state == S_ISSUE);
   assign busy       = (state == S_ISSUE) || (state == S_WAIT) || (state == S_RESP);
   assign master_key = key_reg;

   // The key can only change while no operation is in flight.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         key_reg <= '0;
      end else if (mk_load && ((state == S_BOOT) || (state == S_IDLE))) begin
         key_reg <= master_key_in;
      end
   end

   // Request latch, wait counter, response capture and pointer advance.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         account   <= '0;
         password  <= '0;
         grant     <= '0;
         rr_ptr    <= '0;
         cnt       <= '0;
         resp_data <= '0;
         resp_err  <= 1'b0;
      end else begin
         unique case (state)
            S_IDLE: begin
               if (handshake) begin
                  account  <= acct_slice[winner];
                  password <= pass_slice[winner];
                  grant    <= winner;
               end
            end
            S_ISSUE: begin
               cnt <= '0;
            end
            S_WAIT: begin
               if (done) begin
                  resp_data <= password_enc;
                  resp_err  <= 1'b0;
               end else if (cnt == CNT_LAST) begin
                  resp_data <= '0;
                  resp_err  <= 1'b1;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            S_RESP: begin
               rr_ptr <= (grant == IDX_LAST) ? '0 : grant + IDX_W'(1);
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_wrapper_req_sched.sv
// Randomised directed bench for wrapper_req_sched against a transaction-level
// model of arbitration order, key locking, response data and timeout.
module tb_wrapper_req_sched;

   localparam int NUM_REQ = 4;
   localparam int DATA_W  = 128;
   localparam int TIMEOUT = 16;

   logic                       clk;
   logic                       rst;
   logic [NUM_REQ-1:0]         req_valid;
   logic [NUM_REQ-1:0]         req_ready;
   logic [NUM_REQ*DATA_W-1:0]  req_account;
   logic [NUM_REQ*DATA_W-1:0]  req_password;
   logic                       mk_load;
   logic [DATA_W-1:0]          master_key_in;
   logic [NUM_REQ-1:0]         resp_valid;
   logic [DATA_W-1:0]          resp_data;
   logic                       resp_err;
   logic                       busy;
   logic [DATA_W-1:0]          account;
   logic [DATA_W-1:0]          password;
   logic [DATA_W-1:0]          master_key;
   logic                       go;
   logic [DATA_W-1:0]          password_enc;
   logic                       boot_done_signal;
   logic                       done;

   int checks;
   int failures;

   int                 rr_model;
   logic [DATA_W-1:0]  key_model;
   logic [DATA_W-1:0]  last_data;
   logic               last_err;
   logic [DATA_W-1:0]  acct [NUM_REQ];
   logic [DATA_W-1:0]  pw   [NUM_REQ];

   wrapper_req_sched #(
      .NUM_REQ(NUM_REQ),
      .DATA_W (DATA_W),
      .TIMEOUT(TIMEOUT)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .req_valid       (req_valid),
      .req_ready       (req_ready),
      .req_account     (req_account),
      .req_password    (req_password),
      .mk_load         (mk_load),
      .master_key_in   (master_key_in),
      .resp_valid      (resp_valid),
      .resp_data       (resp_data),
      .resp_err        (resp_err),
      .busy            (busy),
      .account         (account),
      .password        (password),
      .master_key      (master_key),
      .go              (go),
      .password_enc    (password_enc),
      .boot_done_signal(boot_done_signal),
      .done            (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always_comb begin
      for (int i = 0; i < NUM_REQ; i++) begin
         req_account[i*DATA_W +: DATA_W]  = acct[i];
         req_password[i*DATA_W +: DATA_W] = pw[i];
      end
   end

   function automatic logic [DATA_W-1:0] rand128();
      return {$urandom(), $urandom(), $urandom(), $urandom()};
   endfunction

   // Client that the round-robin rule should pick from the model pointer.
   function automatic int expected_winner(input logic [NUM_REQ-1:0] pat);
      for (int k = 0; k < NUM_REQ; k++) begin
         int i;
         i = (rr_model + k) % NUM_REQ;
         if (pat[i[1:0]]) return i;
      end
      return -1;
   endfunction

   task automatic check_output(input string tag, input logic [DATA_W-1:0] obs,
                               input logic [DATA_W-1:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One full request: enter IDLE, grant, issue, wait for done (delay d in
   // WAIT cycles; d >= TIMEOUT means never), then observe the response.
   task automatic apply_stimulus(input logic [NUM_REQ-1:0] pat, input int d,
                                 input bit noise, input logic [DATA_W-1:0] enc);
      int  w;
      bit  hit;
      @(negedge clk);
      mk_load = 1'b0;
      done    = 1'b0;
      boot_done_signal = 1'b1;
      for (int i = 0; i < NUM_REQ; i++) begin
         acct[i] = rand128();
         pw[i]   = rand128();
      end
      req_valid = pat;
      w = expected_winner(pat);
      #1;
      check_output("idle_ready", req_ready, 4'b0001 << w);
      check_output("idle_busy", busy, 0);
      check_output("idle_resp_valid", resp_valid, 0);
      check_output("idle_resp_data_hold", resp_data, last_data);
      check_output("idle_resp_err_hold", resp_err, last_err);
      check_output("idle_key", master_key, key_model);

      @(negedge clk);
      done = noise;
      #1;
      check_output("issue_go", go, 1);
      check_output("issue_busy", busy, 1);
      check_output("issue_ready", req_ready, 0);
      check_output("issue_account", account, acct[w]);
      check_output("issue_password", password, pw[w]);

      hit = 1'b0;
      for (int k = 0; k < TIMEOUT; k++) begin
         @(negedge clk);
         hit          = (k == d);
         done         = hit;
         password_enc = hit ? enc : rand128();
         if (k == 0 && noise) begin
            mk_load          = 1'b1;
            master_key_in    = rand128();
            boot_done_signal = 1'b0;
         end else begin
            mk_load          = 1'b0;
            boot_done_signal = 1'b1;
         end
         #1;
         check_output("wait_go", go, 0);
         check_output("wait_busy", busy, 1);
         check_output("wait_account", account, acct[w]);
         check_output("wait_password", password, pw[w]);
         check_output("wait_key_locked", master_key, key_model);
         if (hit) break;
      end

      @(negedge clk);
      done             = 1'b0;
      mk_load          = 1'b0;
      boot_done_signal = 1'b1;
      password_enc     = rand128();
      last_data = hit ? enc : '0;
      last_err  = !hit;
      #1;
      check_output("resp_valid", resp_valid, 4'b0001 << w);
      check_output("resp_data", resp_data, last_data);
      check_output("resp_err", resp_err, last_err);
      check_output("resp_busy", busy, 1);
      check_output("resp_key_locked", master_key, key_model);
      rr_model = (w + 1) % NUM_REQ;
   endtask

   task automatic load_key(input logic [DATA_W-1:0] k);
      @(negedge clk);
      req_valid     = '0;
      done          = 1'b0;
      mk_load       = 1'b1;
      master_key_in = k;
      #1;
      check_output("key_before_load", master_key, key_model);
      @(negedge clk);
      mk_load   = 1'b0;
      key_model = k;
      #1;
      check_output("key_after_load", master_key, key_model);
   endtask

   initial begin
      checks           = 0;
      failures         = 0;
      rr_model         = 0;
      key_model        = '0;
      last_data        = '0;
      last_err         = 1'b0;
      rst              = 1'b0;
      req_valid        = 4'b1111;
      mk_load          = 1'b0;
      master_key_in    = '0;
      password_enc     = '0;
      boot_done_signal = 1'b0;
      done             = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         acct[i] = '0;
         pw[i]   = '0;
      end

      #1;
      check_output("reset_ready", req_ready, 0);
      check_output("reset_go", go, 0);
      check_output("reset_busy", busy, 0);
      check_output("reset_key", master_key, 0);
      check_output("reset_resp_err", resp_err, 0);

      // Boot gating: a request sits unanswered until the wrapper is booted.
      @(negedge clk);
      rst       = 1'b1;
      req_valid = 4'b0001;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         #1;
         check_output("boot_ready", req_ready, 0);
         check_output("boot_go", go, 0);
      end
      mk_load          = 1'b1;
      master_key_in    = {16{8'hA5}};
      key_model        = {16{8'hA5}};
      boot_done_signal = 1'b1;
      #1;
      check_output("boot_edge_ready", req_ready, 0);
      apply_stimulus(4'b0001, 2, 1'b0, rand128());

      $display("[TB] single operation on client 2");
      apply_stimulus(4'b0100, 4, 1'b0, 128'hDEAD);

      $display("[TB] timeout then normal service");
      apply_stimulus(4'b0010, 1000, 1'b0, rand128());
      apply_stimulus(4'b0011, TIMEOUT - 1, 1'b0, rand128());

      $display("[TB] key lock during operation");
      apply_stimulus(4'b1000, 6, 1'b1, rand128());
      load_key(rand128());

      $display("[TB] boot_done drop while idle");
      @(negedge clk);
      req_valid        = 4'b1000;
      boot_done_signal = 1'b0;
      #1;
      check_output("bootdrop_ready", req_ready, 0);
      @(negedge clk);
      #1;
      check_output("bootdrop_ready_boot", req_ready, 0);
      check_output("bootdrop_busy", busy, 0);
      boot_done_signal = 1'b1;
      #1;
      check_output("bootdrop_still_boot", req_ready, 0);

      $display("[TB] reset in the middle of an operation");
      @(negedge clk);
      req_valid = 4'b0010;
      #1;
      check_output("midrst_ready", req_ready, 4'b0010);
      @(negedge clk);
      req_valid = '0;
      @(negedge clk);
      @(negedge clk);
      rst       = 1'b0;
      req_valid = 4'b1111;
      #1;
      check_output("midrst_busy", busy, 0);
      check_output("midrst_go", go, 0);
      check_output("midrst_ready_zero", req_ready, 0);
      check_output("midrst_account", account, 0);
      check_output("midrst_password", password, 0);
      check_output("midrst_key", master_key, 0);
      check_output("midrst_resp_data", resp_data, 0);
      @(negedge clk);
      rst       = 1'b1;
      req_valid = '0;
      rr_model  = 0;
      key_model = '0;
      last_data = '0;
      last_err  = 1'b0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         #1;
         check_output("postrst_resp_valid", resp_valid, 0);
         check_output("postrst_busy", busy, 0);
      end

      $display("[TB] round robin with all clients requesting");
      for (int j = 0; j < 5; j++) begin
         apply_stimulus(4'b1111, 2, 1'b0, rand128());
      end

      $display("[TB] randomised traffic");
      for (int j = 0; j < 25; j++) begin
         apply_stimulus(4'($urandom_range(1, 15)), int'($urandom_range(0, 20)),
                        1'($urandom_range(0, 1)), rand128());
         if ($urandom_range(0, 3) == 0) load_key(rand128());
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "[TB] simulation did not finish");
   end

endmodule
